// File: rtl/button_debounce_sync.sv
// rtl/button_debounce_sync.sv - push-button synchroniser, debouncer and edge strober for a flip-flop D input
// Optional abort counter port enabled by BUTTON_DEBOUNCE_GLITCH_COUNT_EN.
module button_debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic       input_clock1_clk_1,
  input  logic       input_input_switch4__clear_4,
  input  logic       input_push_button2_raw_2,
  output logic       output_d_level,
  output logic       output_rise_pulse,
  output logic       output_fall_pulse,
`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
  output logic [7:0] output_glitch_count,
`endif
  output logic       output_busy
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    QUAL_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    QUAL_LOW    = 2'd3
  } state_t;

  localparam state_t             RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  assign s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = QUAL_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = QUAL_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
    // busy follows the state being entered so it lines up with the registered state
    busy_d = (state_d == QUAL_HIGH) || (state_d == QUAL_LOW);
  end

  always_ff @(posedge input_clock1_clk_1 or negedge input_input_switch4__clear_4) begin
    if (!input_input_switch4__clear_4) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= input_push_button2_raw_2;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign output_d_level    = level_q;
  assign output_rise_pulse = rise_q;
  assign output_fall_pulse = fall_q;
  assign output_busy       = busy_q;

`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
  logic       abort;
  logic [7:0] glitch_q, glitch_d;

  assign abort = ((state_q == QUAL_HIGH) && !s) || ((state_q == QUAL_LOW) && s);

  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge input_clock1_clk_1 or negedge input_input_switch4__clear_4) begin
    if (!input_input_switch4__clear_4) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign output_glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_button_debounce_sync.sv
// tb/tb_button_debounce_sync.sv - directed self-checking bench for button_debounce_sync
// Glitch counter checks are compiled in with BUTTON_DEBOUNCE_GLITCH_COUNT_EN.
module tb_button_debounce_sync;

  logic       clk;
  logic       rst_n;
  logic       raw;
  logic       d_level;
  logic       rise;
  logic       fall;
  logic       busy;
`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
  logic [7:0] glitch;
`endif

  int checks;
  int errors;

  button_debounce_sync dut (
    .input_clock1_clk_1           (clk),
    .input_input_switch4__clear_4 (rst_n),
    .input_push_button2_raw_2     (raw),
    .output_d_level               (d_level),
    .output_rise_pulse            (rise),
    .output_fall_pulse            (fall),
`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
    .output_glitch_count          (glitch),
`endif
    .output_busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic any_rise, any_fall, any_level;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    raw    = 1'b1;

    // reset held with raw high: outputs stay at reset values
    repeat (3) tick();
    check("rst_level", {31'd0, d_level}, 32'd0);
    check("rst_rise",  {31'd0, rise},    32'd0);
    check("rst_fall",  {31'd0, fall},    32'd0);
    check("rst_busy",  {31'd0, busy},    32'd0);
`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
    check("rst_glitch", {24'd0, glitch}, 32'd0);
`endif

    // release between edges; edge 1 is the first to sample raw
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("rel_busy_e%0d", e),  {31'd0, busy},    (e >= 3 && e <= 5) ? 32'd1 : 32'd0);
      check($sformatf("rel_level_e%0d", e), {31'd0, d_level}, (e >= 6) ? 32'd1 : 32'd0);
      check($sformatf("rel_rise_e%0d", e),  {31'd0, rise},    (e == 6) ? 32'd1 : 32'd0);
    end

    // stable high, then clean 1->0 step
    repeat (3) tick();
    check("hold_high", {31'd0, d_level}, 32'd1);
    raw = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("fall_busy_e%0d", e),  {31'd0, busy},    (e >= 3 && e <= 5) ? 32'd1 : 32'd0);
      check($sformatf("fall_level_e%0d", e), {31'd0, d_level}, (e >= 6) ? 32'd0 : 32'd1);
      check($sformatf("fall_pulse_e%0d", e), {31'd0, fall},    (e == 6) ? 32'd1 : 32'd0);
      check($sformatf("fall_rise_e%0d", e),  {31'd0, rise},    32'd0);
    end

    // clean 0->1 step from stable low
    repeat (3) tick();
    raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("step_busy_e%0d", e),  {31'd0, busy},    (e >= 3 && e <= 5) ? 32'd1 : 32'd0);
      check($sformatf("step_level_e%0d", e), {31'd0, d_level}, (e >= 6) ? 32'd1 : 32'd0);
      check($sformatf("step_rise_e%0d", e),  {31'd0, rise},    (e == 6) ? 32'd1 : 32'd0);
    end
    raw = 1'b0;
    repeat (10) tick();
    check("back_low", {31'd0, d_level}, 32'd0);
`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
    check("glitch_before_bounce", {24'd0, glitch}, 32'd0);
`endif

    // bounce 1,1,0,1,1 then 0: two aborted qualifications
    any_rise = 1'b0; any_fall = 1'b0; any_level = 1'b0;
    for (int i = 0; i < 16; i++) begin
      raw = (i == 0 || i == 1 || i == 3 || i == 4) ? 1'b1 : 1'b0;
      tick();
      any_rise  |= rise;
      any_fall  |= fall;
      any_level |= d_level;
    end
    check("bounce_level", {31'd0, any_level}, 32'd0);
    check("bounce_rise",  {31'd0, any_rise},  32'd0);
    check("bounce_fall",  {31'd0, any_fall},  32'd0);
    check("bounce_idle",  {31'd0, busy},      32'd0);
`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
    check("bounce_glitch", {24'd0, glitch}, 32'd2);
`endif

    // asynchronous clear during QUAL_HIGH with cnt=2
    raw = 1'b1;
    repeat (4) tick();
    check("qual_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    raw   = 1'b0;
    #1;
    check("async_busy",  {31'd0, busy},    32'd0);
    check("async_level", {31'd0, d_level}, 32'd0);
    check("async_rise",  {31'd0, rise},    32'd0);
    check("async_fall",  {31'd0, fall},    32'd0);
`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
    check("async_glitch", {24'd0, glitch}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    any_rise = 1'b0; any_level = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      any_rise  |= rise;
      any_level |= d_level;
    end
    check("post_clear_rise",  {31'd0, any_rise},  32'd0);
    check("post_clear_level", {31'd0, any_level}, 32'd0);

`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
    // one-cycle pulses: each is one abort
    for (int i = 0; i < 100; i++) begin
      raw = 1'b1; tick();
      raw = 1'b0; tick();
    end
    repeat (3) tick();
    check("glitch_100", {24'd0, glitch}, 32'd100);
    for (int i = 0; i < 200; i++) begin
      raw = 1'b1; tick();
      raw = 1'b0; tick();
    end
    repeat (3) tick();
    check("glitch_sat", {24'd0, glitch}, 32'd255);
    raw = 1'b1; tick();
    raw = 1'b0;
    repeat (20) tick();
    check("glitch_hold", {24'd0, glitch}, 32'd255);
    check("sat_level",   {31'd0, d_level}, 32'd0);
`endif

    // constant input: outputs hold
    raw = 1'b0;
    repeat (30) tick();
    check("const_level", {31'd0, d_level}, 32'd0);
    check("const_busy",  {31'd0, busy},    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
